// File: rtl/fetch_unit.sv
// Instruction fetch stage. It keeps one imem read outstanding at a time and registers the returned word.
// On accept it takes the redirect target or PC+4 as the next PC, and it traps on a misaligned target.
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            fetch_fault,
    output logic [31:0]     fetch_count
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_RESET, S_REQ, S_HOLD, S_FAULT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_p0;
    logic [31:0]     instr_p0;
    logic [31:0]     count_p0;
    logic [XLEN-1:0] next_pc;
    logic            accept;
    logic            misaligned;

    assign accept     = (state_q == S_HOLD) && instr_ready;
    assign next_pc    = pc_src ? pc_target : pc_plus4;
    assign misaligned = (next_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_RESET;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_fault = 1'b0;
        case (state_q)
            S_RESET: state_d = S_REQ;
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_rvalid) state_d = S_HOLD;
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (accept) state_d = misaligned ? S_FAULT : S_REQ;
            end
            S_FAULT: fetch_fault = 1'b1;
            default: state_d = S_RESET;
        endcase
    end

    // Fetch stage registers: PC, returned instruction word, accept counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_p0    <= RESET_VECTOR;
            instr_p0 <= NOP;
            count_p0 <= '0;
        end else begin
            if (state_q == S_RESET) pc_p0 <= RESET_VECTOR;
            if (state_q == S_REQ && imem_rvalid) instr_p0 <= imem_rdata;
            if (accept) begin
                count_p0 <= count_p0 + 32'd1;
                // A faulting redirect still counts but leaves pc on the offending instruction.
                if (!misaligned) pc_p0 <= next_pc;
            end
        end
    end

    assign imem_addr   = pc_p0;
    assign pc          = pc_p0;
    assign pc_plus4    = pc_p0 + XLEN'(4);
    assign instr       = instr_p0;
    assign fetch_count = count_p0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a transaction-level fetch model drives memory/decode
// responses, pushes expected fetches, and a monitor compares the DUT state each cycle.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic        instr_ready = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_target = 32'h0;

    logic        imem_req, instr_valid, fetch_fault;
    logic [31:0] imem_addr, instr, pc, pc_plus4, fetch_count;
    logic        w_req, w_valid, w_fault;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4, w_count;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
        .pc_src(pc_src), .pc_target(pc_target),
        .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset_n(reset_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(w_valid), .instr_ready(instr_ready),
        .instr(w_instr), .pc(w_pc), .pc_plus4(w_pc4),
        .pc_src(pc_src), .pc_target(pc_target),
        .fetch_fault(w_fault), .fetch_count(w_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          phase = 1;
    int          wait_left = 0;
    int          hold_left = 0;
    bit          exp_req = 0, exp_valid = 0, exp_fault = 0;
    logic [31:0] model_pc = 32'h0;
    logic [31:0] model_pc2 = 32'hFFFF_FFFC;
    logic [31:0] model_cnt = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8) return 32'h0050_0093;
        return {a[29:0], 2'b11} ^ 32'hA5C3_0000;
    endfunction

    function automatic int choose_wait();
        if (phase == 1) return (model_pc == 32'h4) ? 3 : 0;
        return ($urandom_range(0, 7) < 4) ? 0 : int'($urandom_range(1, 3));
    endfunction

    function automatic int choose_hold();
        if (phase == 1) return (model_pc == 32'h8) ? 5 : 0;
        return ($urandom_range(0, 7) < 4) ? 0 : int'($urandom_range(1, 4));
    endfunction

    task automatic start_fetch();
        exp_req   = 1'b1;
        wait_left = choose_wait();
        exp_q.push_back('{model_pc, mem_word(model_pc)});
    endtask

    // One clock of stimulus: a memory that answers after wait_left cycles, and decode that accepts after hold_left.
    task automatic step();
        logic        src;
        logic [31:0] tgt, nxt, nxt2;
        @(negedge clk);
        imem_rvalid = 1'($urandom_range(0, 1));
        instr_ready = 1'($urandom_range(0, 1));
        pc_src      = 1'($urandom_range(0, 1));
        pc_target   = $urandom;
        imem_rdata  = mem_word(imem_addr);
        if (exp_req) begin
            imem_rvalid = (wait_left == 0);
            if (wait_left == 0) begin
                exp_req   = 1'b0;
                exp_valid = 1'b1;
                hold_left = choose_hold();
            end else begin
                wait_left--;
            end
        end else if (exp_valid) begin
            instr_ready = (hold_left == 0);
            if (hold_left != 0) begin
                hold_left--;
            end else begin
                if (phase == 1) begin
                    src = (model_pc == 32'h10);
                    tgt = 32'h40;
                end else if (phase == 3) begin
                    src = 1'b1;
                    tgt = 32'h42;
                end else begin
                    src = ($urandom_range(0, 3) == 0);
                    tgt = $urandom & 32'hFFFF_FFFC;
                end
                pc_src    = src;
                pc_target = tgt;
                nxt       = src ? tgt : model_pc + 32'd4;
                nxt2      = src ? tgt : model_pc2 + 32'd4;
                model_cnt = model_cnt + 32'd1;
                exp_valid = 1'b0;
                if (nxt[1:0] != 2'b00) begin
                    exp_fault = 1'b1;
                end else begin
                    model_pc  = nxt;
                    model_pc2 = nxt2;
                    start_fetch();
                end
            end
        end
    endtask

    task automatic do_reset(input int cycles, input bit check_now);
        reset_n   = 1'b0;
        exp_req   = 1'b0;
        exp_valid = 1'b0;
        exp_fault = 1'b0;
        model_cnt = 32'h0;
        model_pc  = 32'h0;
        model_pc2 = 32'hFFFF_FFFC;
        exp_q.delete();
        if (check_now) begin
            #1;
            chkb("async_reset_req", imem_req, 1'b0);
            chkb("async_reset_valid", instr_valid, 1'b0);
            chkb("async_reset_wrap_req", w_req, 1'b0);
            chk("async_reset_count", fetch_count, 32'h0);
        end
        repeat (cycles) begin
            @(negedge clk);
            imem_rvalid = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
        end
        reset_n = 1'b1;
        start_fetch();
    endtask

    // Monitor: compare DUT state with the model one time unit after each rising edge.
    initial begin
        logic prev_valid;
        exp_t cur;
        prev_valid = 1'b0;
        cur = '{32'h0, 32'h13};
        forever begin
            @(posedge clk);
            #1;
            chkb("imem_req", imem_req, exp_req);
            chkb("instr_valid", instr_valid, exp_valid);
            chkb("fetch_fault", fetch_fault, exp_fault);
            chk("pc", pc, model_pc);
            chk("pc_plus4", pc_plus4, model_pc + 32'd4);
            chk("fetch_count", fetch_count, model_cnt);
            chk("wrap_pc", w_pc, model_pc2);
            chk("wrap_pc_plus4", w_pc4, model_pc2 + 32'd4);
            chkb("wrap_req", w_req, exp_req);
            if (exp_req) begin
                chk("imem_addr", imem_addr, model_pc);
                chk("wrap_imem_addr", w_addr, model_pc2);
            end
            if (instr_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard: instruction at pc %08h presented, none expected", pc);
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            if (instr_valid) begin
                chk("instr", instr, cur.word);
                chk("instr_pc", pc, cur.pc);
            end
            if (!reset_n) chk("reset_instr", instr, 32'h0000_0013);
            prev_valid = instr_valid;
        end
    end

    initial begin
        logic [31:0] cnt_at_fault;
        phase = 1;
        do_reset(3, 1'b0);
        for (int i = 0; i < 300 && model_cnt < 32'd20; i++) step();

        phase = 2;
        for (int i = 0; i < 3000; i++) step();

        for (int i = 0; i < 50 && !exp_req; i++) step();
        @(negedge clk);
        chkb("req_before_reset", imem_req, 1'b1);
        do_reset(3, 1'b1);
        for (int i = 0; i < 200; i++) step();

        phase = 3;
        for (int i = 0; i < 50 && !exp_fault; i++) step();
        chkb("fault_reached", exp_fault, 1'b1);
        cnt_at_fault = model_cnt;
        for (int i = 0; i < 20; i++) step();
        @(posedge clk);
        #2;
        chkb("fault_sticky", fetch_fault, 1'b1);
        chk("fault_count", fetch_count, cnt_at_fault);
        chkb("fault_no_req", imem_req, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the sample processor: holds the program counter, issues one instruction-memory read at a time over a request/valid handshake, registers the returned word and presents it with its PC to decode and control. When decode accepts the instruction, the block takes the next PC from the controller's branch/jump outcome (PCSrc plus the computed target) or from PC+4. It also traps misaligned fetch targets and counts accepted instructions.

## Interface
- XLEN, 32, datapath and address width
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- imem_req  output  1  read request; held high until imem_rvalid
- imem_addr  output  XLEN  fetch address; stable while imem_req=1
- imem_rvalid  input  1  read data valid; sampled only while imem_req=1
- imem_rdata  input  32  instruction word
- instr_valid  output  1  instr, pc and pc_plus4 are valid
- instr_ready  input  1  decode accepts the instruction this cycle
- instr  output  32  registered instruction word
- pc  output  XLEN  address of instr
- pc_plus4  output  XLEN  pc + 4, modulo 2^XLEN
- pc_src  input  1  redirect for the current instruction; sampled only on accept
- pc_target  input  XLEN  redirect target; sampled only on accept
- fetch_fault  output  1  sticky misaligned-target fault
- fetch_count  output  32  number of accepted instructions; wraps

## Operation
- States:
  - RESET: entered on reset.
  - REQ: memory read outstanding.
  - HOLD: instruction valid, waiting for accept.
  - FAULT: terminal.
- RESET -> REQ: unconditional, on the first clock edge after reset_n deasserts. pc is set to RESET_VECTOR.
- REQ:
  - imem_req=1 and imem_addr=pc.
  - On imem_rvalid: instr <= imem_rdata, then go to HOLD.
  - Otherwise stay in REQ, holding the address.
- HOLD:
  - instr_valid=1 and imem_req=0.
  - Accept is instr_valid & instr_ready. On accept:
    - next = pc_src ? pc_target : pc_plus4.
    - fetch_count increments.
    - If next[1:0] != 0, go to FAULT and leave pc unchanged.
    - Otherwise pc <= next and go to REQ.
  - Without accept, instr, pc and pc_plus4 hold.
- FAULT:
  - fetch_fault=1, instr_valid=0, imem_req=0.
  - Exit only through reset.
- The accepting instruction is counted even when its redirect faults.
- Only one memory request is ever outstanding, and no request is in flight across a redirect. Flush logic is not needed.
- pc_target is used exactly as supplied. Arithmetic wraps modulo 2^XLEN: pc=32'hFFFF_FFFC gives pc_plus4=0.
- Reset values:
  - imem_req=0, imem_addr=RESET_VECTOR.
  - instr_valid=0, instr=32'h0000_0013 (NOP).
  - pc=RESET_VECTOR, pc_plus4=RESET_VECTOR+4.
  - fetch_fault=0, fetch_count=0.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronously), including during an outstanding request. A late imem_rvalid after reset is ignored unless the block is in REQ.

## Timing
- All outputs are registered or decoded from state only; no combinational input-to-output path. imem_addr is the pc register.
- First request: imem_req=1 in the first cycle after the first clock edge following reset_n rise.
- imem_rvalid may assert in the same cycle imem_req first rises (zero-wait memory) or any number of cycles later.
- Fetch latency: instr_valid=1 in the cycle after the imem_rvalid cycle.
- Throughput: with zero-wait memory and instr_ready held at 1, one instruction every 2 cycles (REQ, HOLD, REQ, ...).
- Redirect: the first request to the new target is in the cycle after accept. Redirect costs no extra cycle over sequential fetch.
- In HOLD, instr_ready may stay low indefinitely; pc_src and pc_target are don't-care until accept.

## Test plan
- Reset and sequential fetch:
  - Stimulus: reset_n low for 3 cycles, then high; zero-wait memory; instr_ready=1.
  - Required: imem_addr sequence 0, 4, 8, 12; instr_valid pulses every 2nd cycle; fetch_count=4 after the fourth accept.
- Wait states:
  - Stimulus: imem_rvalid delayed 3 cycles on addr 4.
  - Required: imem_req and imem_addr=4 stable for 4 cycles; instr_valid stays 0 until the cycle after rvalid.
- Backpressure:
  - Stimulus: instr_ready=0 for 5 cycles in HOLD with instr=32'h00500093, pc=8.
  - Required: instr and pc hold, imem_req=0, fetch_count unchanged; after ready rises, the next request is to 12.
- Taken branch:
  - Stimulus: accept at pc=16 with pc_src=1, pc_target=32'h40.
  - Required: next imem_addr=32'h40; pc_plus4=32'h44 once the new instruction is valid.
- Misaligned target:
  - Stimulus: accept with pc_src=1, pc_target=32'h42.
  - Required: fetch_fault=1 next cycle and stays 1; no further imem_req; fetch_count incremented once; pc unchanged.
- Reset mid-request and wrap-around:
  - Stimulus: drop reset_n while in REQ. Separately, set RESET_VECTOR=32'hFFFF_FFFC.
  - Required: the reset drop zeroes imem_req and instr_valid immediately. With the 32'hFFFF_FFFC vector, pc_plus4=0 and the second fetch address is 0.
